// File: rtl/histogram_threshold_if.sv
// Handshake bundle for histogram_threshold: histogram in, threshold out.
// slave = threshold block side, master = upstream/downstream side.
//   i_histogram_flat : 256 bins, bin j at [j*COUNT_W +: COUNT_W]
//   i_valid/o_ready  : histogram handshake
//   i_frac_q8        : target fraction, Q0.8
//   i_offset         : added to the found bin index
//   o_threshold      : min(bin + offset, 255)
//   o_total          : sum of all bins of the accepted histogram
//   o_valid/i_ready  : result handshake
interface histogram_threshold_if #(
    parameter int COUNT_W = 16,
    parameter int TOTAL_W = 24
);
    logic [256*COUNT_W-1:0] i_histogram_flat;
    logic                   i_valid;
    logic                   o_ready;
    logic [7:0]             i_frac_q8;
    logic [7:0]             i_offset;
    logic [7:0]             o_threshold;
    logic [TOTAL_W-1:0]     o_total;
    logic                   o_valid;
    logic                   i_ready;

    modport slave (
        input  i_histogram_flat,
        input  i_valid,
        output o_ready,
        input  i_frac_q8,
        input  i_offset,
        output o_threshold,
        output o_total,
        output o_valid,
        input  i_ready
    );

    modport master (
        output i_histogram_flat,
        output i_valid,
        input  o_ready,
        output i_frac_q8,
        output i_offset,
        input  o_threshold,
        input  o_total,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/histogram_threshold.sv
// Percentile threshold finder: sums a 256-bin histogram, then scans the
// cumulative distribution for the first bin reaching total*frac/256.
// Ports:
//   i_clk     : clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : histogram_threshold_if.slave (histogram in, result out)
module histogram_threshold #(
    parameter int COUNT_W = 16,
    parameter int TOTAL_W = 24
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    histogram_threshold_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUM,
        S_TARGET,
        S_SCAN,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [COUNT_W-1:0] r_bin [256];
    logic [7:0]         r_idx;
    logic [7:0]         r_frac;
    logic [7:0]         r_offset;
    logic [TOTAL_W-1:0] r_total;
    logic [TOTAL_W-1:0] r_cum;
    logic [TOTAL_W-1:0] r_target;
    logic [TOTAL_W-1:0] r_total_out;
    logic [7:0]         r_threshold;
    logic               r_ready;
    logic               r_valid;

    logic               w_accept;
    logic [TOTAL_W-1:0] w_bin;
    logic [TOTAL_W-1:0] w_cum_next;
    logic [TOTAL_W-1:0] w_target;
    logic               w_found;
    logic [8:0]         w_thr_sum;
    logic [7:0]         w_thr_sat;

    assign w_accept   = bus.i_valid && r_ready;
    assign w_bin      = {{(TOTAL_W-COUNT_W){1'b0}}, r_bin[r_idx]};
    assign w_cum_next = r_cum + w_bin;
    // Full 32-bit product so the >>8 keeps every significant bit.
    assign w_target   = TOTAL_W'((32'(r_total) * 32'(r_frac)) >> 8);
    // Guaranteed true by bin 255 because frac <= 255/256.
    assign w_found    = (w_cum_next >= r_target);
    assign w_thr_sum  = {1'b0, r_idx} + {1'b0, r_offset};
    assign w_thr_sat  = w_thr_sum[8] ? 8'hFF : w_thr_sum[7:0];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SUM;
            S_SUM:    if (r_idx == 8'd255) w_next = S_TARGET;
            S_TARGET: w_next = S_SCAN;
            S_SCAN:   if (w_found) w_next = S_OUT;
            S_OUT:    if (bus.i_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int j = 0; j < 256; j++) begin
                r_bin[j] <= '0;
            end
            r_idx       <= '0;
            r_frac      <= '0;
            r_offset    <= '0;
            r_total     <= '0;
            r_cum       <= '0;
            r_target    <= '0;
            r_total_out <= '0;
            r_threshold <= '0;
            r_ready     <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            // Registered so ready only rises one edge after reset release.
            r_ready <= (w_next == S_IDLE);
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        for (int j = 0; j < 256; j++) begin
                            r_bin[j] <= bus.i_histogram_flat[j*COUNT_W +: COUNT_W];
                        end
                        r_frac   <= bus.i_frac_q8;
                        r_offset <= bus.i_offset;
                        r_total  <= '0;
                        r_idx    <= '0;
                    end
                end
                S_SUM: begin
                    r_total <= r_total + w_bin;
                    r_idx   <= r_idx + 8'd1;
                end
                S_TARGET: begin
                    r_target <= w_target;
                    r_cum    <= '0;
                    r_idx    <= '0;
                end
                S_SCAN: begin
                    if (w_found) begin
                        r_threshold <= w_thr_sat;
                        r_total_out <= r_total;
                        r_valid     <= 1'b1;
                    end else begin
                        r_cum <= w_cum_next;
                        r_idx <= r_idx + 8'd1;
                    end
                end
                S_OUT: begin
                    if (bus.i_ready) r_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_ready     = r_ready;
    assign bus.o_valid     = r_valid;
    assign bus.o_threshold = r_threshold;
    assign bus.o_total     = r_total_out;

endmodule

// File: tb/tb_histogram_threshold.sv
// Randomized bench for histogram_threshold with a percentile model.
// Ports: none (instantiates the DUT and its interface).
module tb_histogram_threshold;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    histogram_threshold_if bus ();

    histogram_threshold dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    typedef struct {
        int thr;
        int tot;
        int k;
        int acc;
    } exp_t;

    int   nvec = 0;
    int   nerr = 0;
    exp_t q[$];
    exp_t pend_e;
    bit   pend = 0;
    bit   hs = 0;
    bit   prev_v = 0;

    function automatic void chk(string name, longint act, longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endfunction

    // Percentile rule: first bin whose running sum reaches total*frac/256.
    function automatic exp_t model(input logic [4095:0] h,
                                   input logic [7:0] frac,
                                   input logic [7:0] off);
        exp_t   e;
        longint tot = 0;
        longint cum = 0;
        longint tgt;
        for (int j = 0; j < 256; j++) tot += longint'(h[j*16 +: 16]);
        tgt = (tot * longint'(frac)) / 256;
        e.k = -1;
        for (int j = 0; j < 256; j++) begin
            cum += longint'(h[j*16 +: 16]);
            if (e.k < 0 && cum >= tgt) e.k = j;
        end
        e.thr = (e.k + int'(off) > 255) ? 255 : e.k + int'(off);
        e.tot = int'(tot);
        e.acc = 0;
        return e;
    endfunction

    function automatic logic [4095:0] one_bin(int b, int cnt);
        logic [4095:0] h = '0;
        h[b*16 +: 16] = 16'(cnt);
        return h;
    endfunction

    function automatic logic [4095:0] fill(int v);
        logic [4095:0] h;
        for (int j = 0; j < 256; j++) h[j*16 +: 16] = 16'(v);
        return h;
    endfunction

    function automatic logic [4095:0] rand_hist();
        logic [4095:0] h;
        int mode = $urandom_range(0, 2);
        for (int j = 0; j < 256; j++) begin
            case (mode)
                0: h[j*16 +: 16] = ($urandom_range(0, 15) == 0) ?
                                   16'($urandom) : 16'd0;
                1: h[j*16 +: 16] = 16'($urandom);
                default: h[j*16 +: 16] = 16'($urandom_range(0, 40));
            endcase
        end
        return h;
    endfunction

    // Single compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            pend   = 0;
            hs     = 0;
            prev_v = 0;
        end else begin
            if (hs) begin
                void'(q.pop_front());
                chk("valid_drop", bus.o_valid, 0);
                chk("ready_after_hs", bus.o_ready, 1);
                hs = 0;
            end
            if (pend) begin
                pend_e.acc = cyc;
                q.push_back(pend_e);
                pend = 0;
            end
            if (q.size() != 0) chk("busy_ready", bus.o_ready, 0);
            if (bus.o_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    chk("threshold", bus.o_threshold, q[0].thr);
                    chk("total", bus.o_total, q[0].tot);
                    if (!prev_v)
                        chk("latency", cyc - q[0].acc, 258 + q[0].k);
                    if (bus.i_ready) hs = 1;
                end
            end
            if (bus.i_valid && bus.o_ready) begin
                pend_e = model(bus.i_histogram_flat, bus.i_frac_q8,
                               bus.i_offset);
                pend = 1;
            end
            prev_v = bus.o_valid;
        end
    end

    task automatic present(input logic [4095:0] h, input logic [7:0] f,
                           input logic [7:0] o);
        bus.i_histogram_flat = h;
        bus.i_frac_q8 = f;
        bus.i_offset = o;
        bus.i_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge clk);
            ok = bus.i_valid && bus.o_ready;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_histogram_flat = rand_hist();
        bus.i_frac_q8 = 8'($urandom);
        bus.i_offset = 8'($urandom);
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int n = 0; n < 700 && !ok; n++) begin
            @(negedge clk);
            ok = bus.o_valid;
        end
        if (!ok) chk("valid_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 700 && !ok; n++) begin
            @(negedge clk);
            ok = !bus.o_valid && bus.o_ready;
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [4095:0] h, input logic [7:0] f,
                             input logic [7:0] o, input int stall);
        bus.i_ready = (stall == 0);
        present(h, f, o);
        wait_accept();
        if (stall > 0) begin
            wait_valid();
            repeat (stall) @(posedge clk);
            #1;
            bus.i_ready = 1'b1;
        end
        wait_idle();
    endtask

    exp_t m;

    initial begin
        bus.i_histogram_flat = '0;
        bus.i_valid = 1'b0;
        bus.i_frac_q8 = '0;
        bus.i_offset = '0;
        bus.i_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.o_ready, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_thr", bus.o_threshold, 0);
        chk("rst_total", bus.o_total, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_pre_edge", bus.o_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_first_edge", bus.o_ready, 1);

        m = model(one_bin(10, 4096), 8'd128, 8'd5);
        chk("pin1_thr", m.thr, 15);
        chk("pin1_tot", m.tot, 4096);
        chk("pin1_lat", 258 + m.k, 268);
        m = model(fill(16), 8'd240, 8'd0);
        chk("pin2_thr", m.thr, 239);
        chk("pin2_lat", 258 + m.k, 497);
        m = model(one_bin(250, 777), 8'd128, 8'd20);
        chk("pin3_thr", m.thr, 255);
        m = model(fill(65535), 8'd255, 8'd0);
        chk("pin4_tot", m.tot, 16776960);
        chk("pin4_k", m.k, 254);
        m = model('0, 8'd200, 8'd3);
        chk("pin5_thr", m.thr, 3);
        chk("pin5_lat", 258 + m.k, 258);

        run_frame(one_bin(10, 4096), 8'd128, 8'd5, 0);
        run_frame(fill(16), 8'd240, 8'd0, 0);
        run_frame(one_bin(250, 777), 8'd128, 8'd20, 0);
        run_frame(fill(65535), 8'd255, 8'd0, 0);
        run_frame('0, 8'd200, 8'd3, 0);

        bus.i_ready = 1'b0;
        present(fill(3), 8'd100, 8'd7);
        wait_accept();
        wait_valid();
        present(one_bin(5, 9), 8'd64, 8'd1);
        repeat (10) @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        wait_accept();
        wait_idle();

        present(one_bin(200, 50), 8'd128, 8'd0);
        wait_accept();
        repeat (340) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.o_valid, 0);
        chk("arst_thr", bus.o_threshold, 0);
        chk("arst_total", bus.o_total, 0);
        chk("arst_ready", bus.o_ready, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rel_ready_low", bus.o_ready, 0);
        @(posedge clk);
        #1;
        chk("rel_ready_high", bus.o_ready, 1);
        run_frame(one_bin(42, 1000), 8'd128, 8'd2, 0);

        for (int i = 0; i < 10; i++) begin
            run_frame(rand_hist(), 8'($urandom), 8'($urandom),
                      $urandom_range(0, 4));
        end

        repeat (5) @(negedge clk);
        chk("leftover", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
